// File: rtl/fa_chk_pkg.sv
// Shared types, constants and the golden full-adder function for the result checker.
package fa_chk_pkg;

  // Number of distinct {a,b,cin} input combinations of a 1-bit full adder.
  localparam int unsigned N_COMB = 8;

  // Checker control states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Reference full adder; returns {cout, sum}.
  function automatic logic [1:0] fa_ref(input logic a, input logic b, input logic cin);
    logic sum;
    logic cout;
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
    return {cout, sum};
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Purely combinational golden full adder used as the checker's expected-value source.
module fa_ref_model
  import fa_chk_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Expected outputs straight from the shared reference function.
  always_comb begin
    {cout_o, sum_o} = fa_ref(a_i, b_i, cin_i);
  end

endmodule

// File: rtl/fa_result_checker.sv
// Response monitor for a 1-bit full adder: compares strobed samples against a golden
// model, keeps saturating vector/error counts, coverage of all input combinations,
// the first failing combination, and a done/pass verdict.
module fa_result_checker
  import fa_chk_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              smp_valid_i,
  input  logic              smp_a_i,
  input  logic              smp_b_i,
  input  logic              smp_cin_i,
  input  logic              smp_sum_i,
  input  logic              smp_cout_i,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [N_COMB-1:0] cov_map_o,
  output logic [2:0]        first_err_vec_o,
  output logic              first_err_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [N_COMB-1:0] cov_q, cov_d;
  logic [2:0]        first_err_vec_q, first_err_vec_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic              pass_q, pass_d;

  logic [2:0]        idx;
  logic              exp_sum;
  logic              exp_cout;
  logic              mismatch;
  logic              accept;
  logic [N_COMB-1:0] idx_onehot;
  logic [N_COMB-1:0] cov_upd;
  logic              cov_full;
  logic              finish_run;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign idx = {smp_a_i, smp_b_i, smp_cin_i};

  fa_ref_model u_ref (
    .a_i    (smp_a_i),
    .b_i    (smp_b_i),
    .cin_i  (smp_cin_i),
    .sum_o  (exp_sum),
    .cout_o (exp_cout)
  );

  // Sample qualification, coverage update and run-termination detection.
  always_comb begin
    mismatch   = (smp_sum_i != exp_sum) | (smp_cout_i != exp_cout);
    // start has priority: a sample coinciding with start is discarded.
    accept     = (state_q == StRun) & smp_valid_i & ~start_i;
    idx_onehot = '0;
    idx_onehot[idx] = 1'b1;
    cov_upd    = cov_q | idx_onehot;
    cov_full   = (cov_upd == {N_COMB{1'b1}});
    finish_run = accept & (cov_full | (STOP_ON_FAIL & mismatch));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start re-arms from any state; RUN ends on full coverage or early stop.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StRun:   state_d = finish_run ? StDone : StRun;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
  end

  // Result next-state: clear on start, accumulate on accepted samples, freeze otherwise.
  always_comb begin
    vec_cnt_d         = vec_cnt_q;
    err_cnt_d         = err_cnt_q;
    cov_d             = cov_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;
    pass_d            = pass_q;
    if (start_i) begin
      vec_cnt_d         = '0;
      err_cnt_d         = '0;
      cov_d             = '0;
      first_err_vec_d   = '0;
      first_err_valid_d = 1'b0;
      pass_d            = 1'b0;
    end else if (accept) begin
      vec_cnt_d = sat_inc(vec_cnt_q);
      cov_d     = cov_upd;
      if (mismatch) begin
        err_cnt_d = sat_inc(err_cnt_q);
        if (!first_err_valid_q) begin
          first_err_vec_d   = idx;
          first_err_valid_d = 1'b1;
        end
      end
      // Verdict is latched on the edge that enters DONE, using the updated results.
      if (finish_run) begin
        pass_d = (err_cnt_d == '0) & cov_full;
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q         <= '0;
      err_cnt_q         <= '0;
      cov_q             <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      vec_cnt_q         <= vec_cnt_d;
      err_cnt_q         <= err_cnt_d;
      cov_q             <= cov_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
      pass_q            <= pass_d;
    end
  end

  assign vec_cnt_o         = vec_cnt_q;
  assign err_cnt_o         = err_cnt_q;
  assign cov_map_o         = cov_q;
  assign first_err_vec_o   = first_err_vec_q;
  assign first_err_valid_o = first_err_valid_q;
  assign pass_o            = pass_q;

endmodule

// File: tb/tb_fa_result_checker.sv
// Directed bench for fa_result_checker: default, CNT_W=3 and STOP_ON_FAIL=1 instances
// share one sample bus; each has its own start.
module tb_fa_result_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic smp_valid = 1'b0;
  logic smp_a = 1'b0, smp_b = 1'b0, smp_cin = 1'b0, smp_sum = 1'b0, smp_cout = 1'b0;

  logic [7:0] vec_a, err_a, cov_a;
  logic [2:0] fev_a;
  logic       fevv_a, busy_a, done_a, pass_a;
  logic [2:0] vec_b, err_b;
  logic [7:0] cov_b;
  logic [2:0] fev_b;
  logic       fevv_b, busy_b, done_b, pass_b;
  logic [7:0] vec_c, err_c, cov_c;
  logic [2:0] fev_c;
  logic       fevv_c, busy_c, done_c, pass_c;

  int tests = 0;
  int fails = 0;

  // Hand-computed full-adder truth table, bit i = value for {a,b,cin}=i.
  logic [7:0] gold_s = 8'b1001_0110;
  logic [7:0] gold_c = 8'b1110_1000;

  always #5 clk = ~clk;

  fa_result_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b0)) u_dflt (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .smp_valid_i(smp_valid),
    .smp_a_i(smp_a), .smp_b_i(smp_b), .smp_cin_i(smp_cin), .smp_sum_i(smp_sum),
    .smp_cout_i(smp_cout), .vec_cnt_o(vec_a), .err_cnt_o(err_a), .cov_map_o(cov_a),
    .first_err_vec_o(fev_a), .first_err_valid_o(fevv_a), .busy_o(busy_a),
    .done_o(done_a), .pass_o(pass_a)
  );

  fa_result_checker #(.CNT_W(3), .STOP_ON_FAIL(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .smp_valid_i(smp_valid),
    .smp_a_i(smp_a), .smp_b_i(smp_b), .smp_cin_i(smp_cin), .smp_sum_i(smp_sum),
    .smp_cout_i(smp_cout), .vec_cnt_o(vec_b), .err_cnt_o(err_b), .cov_map_o(cov_b),
    .first_err_vec_o(fev_b), .first_err_valid_o(fevv_b), .busy_o(busy_b),
    .done_o(done_b), .pass_o(pass_b)
  );

  fa_result_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b1)) u_sof (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .smp_valid_i(smp_valid),
    .smp_a_i(smp_a), .smp_b_i(smp_b), .smp_cin_i(smp_cin), .smp_sum_i(smp_sum),
    .smp_cout_i(smp_cout), .vec_cnt_o(vec_c), .err_cnt_o(err_c), .cov_map_o(cov_c),
    .first_err_vec_o(fev_c), .first_err_valid_o(fevv_c), .busy_o(busy_c),
    .done_o(done_c), .pass_o(pass_c)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       flip_s;
    logic       flip_c;
    logic [7:0] vec;
    logic [7:0] err;
    logic [7:0] cov;
    logic       done;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic [2:0] i, input logic fs, input logic fc);
    @(negedge clk);
    {smp_a, smp_b, smp_cin} = i;
    smp_sum   = gold_s[i] ^ fs;
    smp_cout  = gold_c[i] ^ fc;
    smp_valid = 1'b1;
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] m);
    @(negedge clk);
    start_a = m[0];
    start_b = m[1];
    start_c = m[2];
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  initial begin
    // Sweep 1: all correct. Sweep 2: sum inverted on idx 011.
    tbl[0]  = '{3'd0, 1'b0, 1'b0, 8'd1, 8'd0, 8'h01, 1'b0};
    tbl[1]  = '{3'd1, 1'b0, 1'b0, 8'd2, 8'd0, 8'h03, 1'b0};
    tbl[2]  = '{3'd2, 1'b0, 1'b0, 8'd3, 8'd0, 8'h07, 1'b0};
    tbl[3]  = '{3'd3, 1'b0, 1'b0, 8'd4, 8'd0, 8'h0F, 1'b0};
    tbl[4]  = '{3'd4, 1'b0, 1'b0, 8'd5, 8'd0, 8'h1F, 1'b0};
    tbl[5]  = '{3'd5, 1'b0, 1'b0, 8'd6, 8'd0, 8'h3F, 1'b0};
    tbl[6]  = '{3'd6, 1'b0, 1'b0, 8'd7, 8'd0, 8'h7F, 1'b0};
    tbl[7]  = '{3'd7, 1'b0, 1'b0, 8'd8, 8'd0, 8'hFF, 1'b1};
    tbl[8]  = '{3'd0, 1'b0, 1'b0, 8'd1, 8'd0, 8'h01, 1'b0};
    tbl[9]  = '{3'd1, 1'b0, 1'b0, 8'd2, 8'd0, 8'h03, 1'b0};
    tbl[10] = '{3'd2, 1'b0, 1'b0, 8'd3, 8'd0, 8'h07, 1'b0};
    tbl[11] = '{3'd3, 1'b1, 1'b0, 8'd4, 8'd1, 8'h0F, 1'b0};
    tbl[12] = '{3'd4, 1'b0, 1'b0, 8'd5, 8'd1, 8'h1F, 1'b0};
    tbl[13] = '{3'd5, 1'b0, 1'b0, 8'd6, 8'd1, 8'h3F, 1'b0};
    tbl[14] = '{3'd6, 1'b0, 1'b0, 8'd7, 8'd1, 8'h7F, 1'b0};
    tbl[15] = '{3'd7, 1'b0, 1'b0, 8'd8, 8'd1, 8'hFF, 1'b1};

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_vec", vec_a, 0);
    check("rst_err", err_a, 0);
    check("rst_cov", cov_a, 0);
    check("rst_fev", {fevv_a, fev_a}, 0);
    check("rst_flags", {busy_a, done_a, pass_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores samples.
    sample(3'd5, 1'b0, 1'b0);
    check("idle_vec", vec_a, 0);
    check("idle_busy", busy_a, 0);

    // Saturation on CNT_W=3: 10 samples, cout wrong, idx 0/1 only.
    pulse_start(3'b010);
    for (int i = 0; i < 10; i++) sample(3'(i % 2), 1'b0, 1'b1);
    check("sat_vec", vec_b, 7);
    check("sat_err", err_b, 7);
    check("sat_cov", cov_b, 8'h03);
    check("sat_fev", {fevv_b, fev_b}, 4'b1000);
    check("sat_busy", busy_b, 1);

    // STOP_ON_FAIL: error on 2nd sample ends the run; 3rd sample ignored.
    pulse_start(3'b100);
    sample(3'd0, 1'b0, 1'b0);
    check("sof_done1", done_c, 0);
    sample(3'd1, 1'b1, 1'b0);
    check("sof_done2", done_c, 1);
    check("sof_err", err_c, 1);
    check("sof_fev", {fevv_c, fev_c}, 4'b1001);
    check("sof_pass", pass_c, 0);
    sample(3'd2, 1'b0, 1'b0);
    check("sof_vec", vec_c, 2);

    // Exhaustive correct sweep, then injected-error sweep after start in DONE.
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 8) begin
        pulse_start(3'b001);
        check("start_busy", busy_a, 1);
        check("start_clr", {vec_a, err_a, cov_a, fevv_a, pass_a, done_a}, 0);
      end
      sample(tbl[i].idx, tbl[i].flip_s, tbl[i].flip_c);
      check($sformatf("tbl%0d_vec", i), vec_a, tbl[i].vec);
      check($sformatf("tbl%0d_err", i), err_a, tbl[i].err);
      check($sformatf("tbl%0d_cov", i), cov_a, tbl[i].cov);
      check($sformatf("tbl%0d_done", i), done_a, tbl[i].done);
      if (i == 7) begin
        check("exh_pass", pass_a, 1);
        check("exh_fevv", fevv_a, 0);
        sample(3'd2, 1'b1, 1'b0);
        check("done_frozen_vec", vec_a, 8);
        check("done_frozen_err", err_a, 0);
      end
    end
    check("inj_pass", pass_a, 0);
    check("inj_fev", {fevv_a, fev_a}, 4'b1011);

    // Partial coverage: 12 correct samples over idx 0..5.
    pulse_start(3'b001);
    for (int i = 0; i < 12; i++) sample(3'(i % 6), 1'b0, 1'b0);
    check("part_vec", vec_a, 12);
    check("part_cov", cov_a, 8'h3F);
    check("part_busy", {busy_a, done_a}, 2'b10);

    // start together with smp_valid: sample discarded.
    @(negedge clk);
    {smp_a, smp_b, smp_cin} = 3'd7;
    smp_sum   = gold_s[7];
    smp_cout  = gold_c[7];
    smp_valid = 1'b1;
    start_a   = 1'b1;
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
    start_a   = 1'b0;
    check("sv_vec", vec_a, 0);
    check("sv_cov", cov_a, 0);
    check("sv_busy", busy_a, 1);

    // Asynchronous reset mid-RUN.
    sample(3'd3, 1'b1, 1'b0);
    check("pre_rst_err", err_a, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", {vec_a, err_a, cov_a}, 0);
    check("arst_flags", {fevv_a, fev_a, busy_a, done_a, pass_a}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", {busy_a, done_a}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
